// File: rtl/gyro_integrator.sv
// Multi-channel gyro rate integrator with bias calibration, deadband, saturation and zero command.
// Latency 3 cycles from sample_valid_in to angle_valid_out, one sample per cycle, no backpressure.
module gyro_integrator #(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int SHIFT    = 4,
  parameter int CAL_LOG2 = 8,
  parameter int DEADBAND = 4
) (
  input  logic                     clk_100mhz,
  input  logic                     rst_n_in,
  input  logic                     sample_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     cal_start_in,
  input  logic                     zero_in,
  output logic [NUM_CH*DATA_W-1:0] angle_out,
  output logic                     angle_valid_out,
  output logic                     cal_busy_out,
  output logic                     cal_done_out
);

  localparam int CORR_W = DATA_W + 1;
  localparam int SUM_W  = DATA_W + CAL_LOG2;
  localparam int SHR_W  = ACC_W - SHIFT;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_CAL = 1'b1;

  localparam logic [CAL_LOG2-1:0]      CAL_LAST = '1;
  localparam logic signed [CORR_W-1:0] DB_POS   = CORR_W'(DEADBAND);
  localparam logic signed [CORR_W-1:0] DB_NEG   = CORR_W'(-DEADBAND);
  localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SHR_W-1:0]  ANG_MAX  = SHR_W'(2**(DATA_W-1) - 1);
  localparam logic signed [SHR_W-1:0]  ANG_MIN  = SHR_W'(-(2**(DATA_W-1)));

  logic [0:0]                state;
  logic [CAL_LOG2-1:0]       cal_cnt;
  logic signed [DATA_W-1:0]  bias    [NUM_CH];
  logic signed [SUM_W-1:0]   cal_sum [NUM_CH];
  logic                      s1_vld;
  logic signed [CORR_W-1:0]  s1_corr [NUM_CH];
  logic                      s2_vld;
  logic signed [ACC_W-1:0]   acc     [NUM_CH];

  logic signed [DATA_W-1:0]  smp      [NUM_CH];
  logic signed [CORR_W-1:0]  corr_raw [NUM_CH];
  logic signed [CORR_W-1:0]  corr_db  [NUM_CH];
  logic signed [ACC_W:0]     acc_sum  [NUM_CH];
  logic signed [ACC_W-1:0]   acc_nxt  [NUM_CH];
  logic signed [SHR_W-1:0]   acc_shr  [NUM_CH];
  logic signed [SUM_W-1:0]   cal_tot  [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]  ang_nxt;
  logic                      in_run;
  logic                      cal_fin;

  assign in_run       = (state == ST_RUN);
  assign cal_busy_out = (state == ST_CAL);
  assign cal_fin      = (state == ST_CAL) && sample_valid_in && (cal_cnt == CAL_LAST);

  always_comb begin
    ang_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      smp[i]      = sample_in[i*DATA_W +: DATA_W];
      corr_raw[i] = {smp[i][DATA_W-1], smp[i]} - {bias[i][DATA_W-1], bias[i]};
      corr_db[i]  = (corr_raw[i] <= DB_POS && corr_raw[i] >= DB_NEG) ? '0 : corr_raw[i];
      // One extra bit exposes overflow as a mismatch between the top two bits.
      acc_sum[i]  = {acc[i][ACC_W-1], acc[i]} + (ACC_W+1)'(s1_corr[i]);
      if (acc_sum[i][ACC_W] != acc_sum[i][ACC_W-1])
        acc_nxt[i] = acc_sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
      else
        acc_nxt[i] = acc_sum[i][ACC_W-1:0];
      acc_shr[i] = acc[i][ACC_W-1:SHIFT];
      if (acc_shr[i] > ANG_MAX)
        ang_nxt[i*DATA_W +: DATA_W] = DATA_W'(ANG_MAX);
      else if (acc_shr[i] < ANG_MIN)
        ang_nxt[i*DATA_W +: DATA_W] = DATA_W'(ANG_MIN);
      else
        ang_nxt[i*DATA_W +: DATA_W] = DATA_W'(acc_shr[i]);
      cal_tot[i] = cal_sum[i] + SUM_W'(smp[i]);
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_RUN;
      cal_cnt      <= '0;
      cal_done_out <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        bias[i]    <= '0;
        cal_sum[i] <= '0;
      end
    end else begin
      cal_done_out <= 1'b0;
      case (state)
        ST_RUN: begin
          if (cal_start_in) begin
            state   <= ST_CAL;
            cal_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) cal_sum[i] <= '0;
          end
        end
        ST_CAL: begin
          if (sample_valid_in) begin
            if (cal_cnt == CAL_LAST) begin
              // Floor division of the full sum by 2^CAL_LOG2 is just the upper slice.
              for (int i = 0; i < NUM_CH; i++) bias[i] <= cal_tot[i][CAL_LOG2 +: DATA_W];
              cal_done_out <= 1'b1;
              state        <= ST_RUN;
            end else begin
              for (int i = 0; i < NUM_CH; i++) cal_sum[i] <= cal_tot[i];
              cal_cnt <= cal_cnt + CAL_LOG2'(1);
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_vld          <= 1'b0;
      s2_vld          <= 1'b0;
      angle_valid_out <= 1'b0;
      angle_out       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_corr[i] <= '0;
        acc[i]     <= '0;
      end
    end else begin
      // Any sample still in the pipe is dropped once CAL is entered or zero is commanded.
      s1_vld          <= sample_valid_in && in_run && !zero_in;
      s2_vld          <= s1_vld && in_run && !zero_in;
      angle_valid_out <= s2_vld && in_run && !zero_in;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_corr[i] <= corr_db[i];
        if (zero_in || cal_fin)
          acc[i] <= '0;
        else if (s1_vld && in_run)
          acc[i] <= acc_nxt[i];
      end
      if (zero_in || cal_fin)
        angle_out <= '0;
      else if (s2_vld && in_run)
        angle_out <= ang_nxt;
    end
  end

endmodule
